// File: rtl/ysyx_23060229_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060229_pkg
// Shared definitions for the NPC core write-back path:
//   - write-back requester indices (EXU, LSU, CSR)
//   - default register-file geometry and scoreboard counter width
//   - reg_idx_t, the architectural register index type
//   - idx_width(), index width helper for N-way arbiters
// ---------------------------------------------------------------------------
package ysyx_23060229_pkg;

  // Write-back requester indices
  localparam int WB_EXU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_CSR = 2;

  // Default geometry
  localparam int WB_NREQ       = 3;
  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_CNT_WIDTH  = 2;

  typedef logic [WB_ADDR_WIDTH-1:0] reg_idx_t;

  // Width of an index selecting one of n items (at least one bit)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ysyx_23060229_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_23060229_rr_arbiter
// N-way round-robin arbiter. The search for a winner starts just after the
// most recently granted index (last) and wraps; the first requester found
// wins. last only moves when a grant is issued. Shared with the memory-bus
// arbiter.
//
// Ports:
//   clk         in   clock
//   rst         in   asynchronous active-low reset (last <= N-1)
//   en          in   grant enable; when low no grant is issued
//   req         in   N   request vector
//   grant       out  N   one-hot grant (never set without the matching req)
//   grant_valid out  1   a grant is issued this cycle
//   grant_idx   out  IW  index of the granted requester
// ---------------------------------------------------------------------------
module ysyx_23060229_rr_arbiter
  import ysyx_23060229_pkg::*;
#(
  parameter  int N  = 3,
  localparam int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] last;
  logic [IW-1:0] cand;

  // NOTE: every variable written in always_comb gets a default first so that
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_idx   = last;
    cand        = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last) + k) % N);
      if (en && !grant_valid && req[cand]) begin
        grant[cand] = 1'b1;
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= IW'(N - 1);
    end else if (grant_valid) begin
      last <= grant_idx;
    end
  end

endmodule

// File: rtl/ysyx_23060229_wb_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_23060229_wb_arbiter
// Shares the register file's single write port among NREQ result producers
// (EXU, LSU, CSR) with round-robin arbitration and a registered output stage,
// and keeps a per-register outstanding-write count so decode can stall on
// read-after-write hazards.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   flush             discard all outstanding state (counters, pending wen)
//   req_valid/ready   NREQ handshake bits, one per requester
//   req_addr/data     packed per-requester destination index / result data
//   iss_valid/rd      decode issues an instruction writing iss_rd
//   iss_ready         issue accepted (destination counter not saturated)
//   rs1/rs2           source indices; rs1_busy/rs2_busy flag pending writes
//   wen/waddr/wdata   registered register-file write port
// ---------------------------------------------------------------------------
module ysyx_23060229_wb_arbiter
  import ysyx_23060229_pkg::*;
#(
  parameter int NREQ       = WB_NREQ,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int CNT_WIDTH  = WB_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  input  logic                       iss_valid,
  input  logic [ADDR_WIDTH-1:0]      iss_rd,
  output logic                       iss_ready,
  input  logic [ADDR_WIDTH-1:0]      rs1,
  input  logic [ADDR_WIDTH-1:0]      rs2,
  output logic                       rs1_busy,
  output logic                       rs2_busy,
  output logic                       wen,
  output logic [ADDR_WIDTH-1:0]      waddr,
  output logic [DATA_WIDTH-1:0]      wdata
);

  localparam int NREGS = 1 << ADDR_WIDTH;
  localparam int IW    = idx_width(NREQ);

  logic                  grant_valid;
  logic [IW-1:0]         grant_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  logic [CNT_WIDTH-1:0]  cnt [NREGS];
  logic [NREGS-1:0]      inc_vec;
  logic [NREGS-1:0]      dec_vec;
  logic                  iss_fire;

  // -------------------------------------------------------------------------
  // Arbitration: no grant at all during a flush cycle
  // -------------------------------------------------------------------------
  ysyx_23060229_rr_arbiter #(
    .N (NREQ)
  ) u_rr_arbiter (
    .clk         (clk),
    .rst         (rst),
    .en          (!flush),
    .req         (req_valid),
    .grant       (req_ready),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign sel_addr = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

  // -------------------------------------------------------------------------
  // Registered write port. A grant to x0 is consumed but never writes.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen   <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if (flush) begin
      wen <= 1'b0;
    end else if (grant_valid) begin
      wen   <= (sel_addr != '0);
      waddr <= sel_addr;
      wdata <= sel_data;
    end else begin
      wen <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  assign iss_ready = (iss_rd == '0) || (cnt[iss_rd] != {CNT_WIDTH{1'b1}});
  assign iss_fire  = iss_valid && iss_ready && (iss_rd != '0);
  assign rs1_busy  = (rs1 != '0) && (cnt[rs1] != '0);
  assign rs2_busy  = (rs2 != '0) && (cnt[rs2] != '0);

  // A commit to a register whose count is already 0 is a legal untracked
  // write; it simply does not decrement.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (iss_fire) begin
      inc_vec[iss_rd] = 1'b1;
    end
    if (wen && (cnt[waddr] != '0)) begin
      dec_vec[waddr] = 1'b1;
    end
  end

  // NOTE: the counter array is state that busy/iss_ready read directly, so
  // unlike a data RAM it must be cleared by reset and by flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt[r] <= '0;
      end
    end else if (flush) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          cnt[r] <= cnt[r] + 1'b1;
        end else if (dec_vec[r] && !inc_vec[r]) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060229_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060229_wb_arbiter
// Self-checking bench for the write-back arbiter and scoreboard. Expected
// register-file writes are queued when a grant is expected and compared
// against wen/waddr/wdata on the following cycle. Inputs change 1 ns after
// the rising edge; combinational outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ysyx_23060229_wb_arbiter;
  import ysyx_23060229_pkg::*;

  localparam int NREQ = WB_NREQ;
  localparam int AW   = WB_ADDR_WIDTH;
  localparam int DW   = WB_DATA_WIDTH;
  localparam int CW   = WB_CNT_WIDTH;

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               iss_valid;
  reg_idx_t           iss_rd;
  logic               iss_ready;
  reg_idx_t           rs1;
  reg_idx_t           rs2;
  logic               rs1_busy;
  logic               rs2_busy;
  logic               wen;
  logic [AW-1:0]      waddr;
  logic [DW-1:0]      wdata;

  wr_t exp_q[$];
  wr_t got;
  wr_t want;
  int  checks = 0;
  int  passed = 0;

  always #5 clk = ~clk;

  ysyx_23060229_wb_arbiter #(
    .NREQ       (NREQ),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata)
  );

  // Stimulus helpers (no checking inside)
  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_point();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    iss_valid = 1'b0; iss_rd = 5'd5; rs1 = 5'd5; rs2 = 5'd7;
    sample_point();
    checks++;
    if (wen !== 1'b0) $display("FAIL reset_wen_during: got %b want 0", wen);
    else passed++;
    drive_point();
    drive_point();
    rst = 1'b1;
    sample_point();
    checks++;
    if ({wen, waddr, wdata} !== {1'b0, 5'd0, 32'd0})
      $display("FAIL reset_outputs: got wen=%b waddr=%0d wdata=%h want 0/0/0", wen, waddr, wdata);
    else passed++;
    checks++;
    if ({iss_ready, rs1_busy, rs2_busy, req_ready} !== {1'b1, 1'b0, 1'b0, 3'b000})
      $display("FAIL reset_comb: got iss_ready=%b rs1_busy=%b rs2_busy=%b req_ready=%b want 1/0/0/000",
               iss_ready, rs1_busy, rs2_busy, req_ready);
    else passed++;
    drive_point();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_single_write();
    set_req(WB_EXU, 5'd5, 32'h1234_5678);
    sample_point();
    checks++;
    if (req_ready !== 3'b001) $display("FAIL single_ready: got %b want 001", req_ready);
    else passed++;
    exp_q.push_back({1'b1, 5'd5, 32'h1234_5678});
    drive_point();
    clear_reqs();
    want = exp_q.pop_front();
    got  = {wen, waddr, wdata};
    checks++;
    if (got !== want)
      $display("FAIL single_write: got wen=%b waddr=%0d wdata=%h want wen=%b waddr=%0d wdata=%h",
               got.wen, got.addr, got.data, want.wen, want.addr, want.data);
    else passed++;
    drive_point();
    checks++;
    if ({wen, waddr, wdata} !== {1'b0, 5'd5, 32'h1234_5678})
      $display("FAIL single_hold: got wen=%b waddr=%0d wdata=%h want 0/5/12345678", wen, waddr, wdata);
    else passed++;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_round_robin();
    int order [4] = '{0, 1, 2, 0};
    rst = 1'b0;
    drive_point();
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(10 + i), DW'(32'hA000_0000 + i));
    for (int c = 0; c < 4; c++) begin
      sample_point();
      checks++;
      if (req_ready !== NREQ'(1 << order[c]))
        $display("FAIL rr_grant%0d: got %b want %b", c, req_ready, NREQ'(1 << order[c]));
      else passed++;
      exp_q.push_back({1'b1, AW'(10 + order[c]), DW'(32'hA000_0000 + order[c])});
      drive_point();
      if (c == 3) clear_reqs();
      want = exp_q.pop_front();
      got  = {wen, waddr, wdata};
      checks++;
      if (got !== want)
        $display("FAIL rr_write%0d: got wen=%b waddr=%0d wdata=%h want wen=%b waddr=%0d wdata=%h",
                 c, got.wen, got.addr, got.data, want.wen, want.addr, want.data);
      else passed++;
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_saturate();
    iss_valid = 1'b1; iss_rd = 5'd7; rs1 = 5'd7;
    for (int n = 0; n < 4; n++) begin
      sample_point();
      checks++;
      if (iss_ready !== (n < 3))
        $display("FAIL sat_iss_ready%0d: got %b want %b", n, iss_ready, (n < 3));
      else passed++;
      drive_point();
    end
    iss_valid = 1'b0;
    sample_point();
    checks++;
    if (rs1_busy !== 1'b1) $display("FAIL sat_busy: got %b want 1", rs1_busy);
    else passed++;
    drive_point();
    for (int n = 0; n < 3; n++) begin
      set_req(WB_LSU, 5'd7, DW'(32'h7700 + n));
      sample_point();
      checks++;
      if (req_ready !== 3'b010) $display("FAIL sat_lsu_ready%0d: got %b want 010", n, req_ready);
      else passed++;
      exp_q.push_back({1'b1, 5'd7, DW'(32'h7700 + n)});
      drive_point();
      if (n == 2) clear_reqs();
      want = exp_q.pop_front();
      got  = {wen, waddr, wdata};
      checks++;
      if (got !== want)
        $display("FAIL sat_write%0d: got wen=%b waddr=%0d wdata=%h want wen=%b waddr=%0d wdata=%h",
                 n, got.wen, got.addr, got.data, want.wen, want.addr, want.data);
      else passed++;
    end
    // now in T+1 of the last grant: one commit still pending
    sample_point();
    checks++;
    if (rs1_busy !== 1'b1) $display("FAIL sat_busy_t1: got %b want 1", rs1_busy);
    else passed++;
    drive_point();
    sample_point();
    checks++;
    if (rs1_busy !== 1'b0) $display("FAIL sat_busy_t2: got %b want 0", rs1_busy);
    else passed++;
    drive_point();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_same_edge();
    iss_valid = 1'b1; iss_rd = 5'd9; rs2 = 5'd9;
    drive_point();
    iss_valid = 1'b0;
    set_req(WB_EXU, 5'd9, 32'h0000_0099);
    sample_point();
    checks++;
    if ({req_ready, rs2_busy} !== {3'b001, 1'b1})
      $display("FAIL same_grant: got req_ready=%b rs2_busy=%b want 001/1", req_ready, rs2_busy);
    else passed++;
    exp_q.push_back({1'b1, 5'd9, 32'h0000_0099});
    drive_point();
    clear_reqs();
    iss_valid = 1'b1;
    want = exp_q.pop_front();
    got  = {wen, waddr, wdata};
    checks++;
    if (got !== want)
      $display("FAIL same_write: got wen=%b waddr=%0d wdata=%h want wen=%b waddr=%0d wdata=%h",
               got.wen, got.addr, got.data, want.wen, want.addr, want.data);
    else passed++;
    sample_point();
    checks++;
    if ({iss_ready, rs2_busy} !== 2'b11)
      $display("FAIL same_issue: got iss_ready=%b rs2_busy=%b want 1/1", iss_ready, rs2_busy);
    else passed++;
    drive_point();
    iss_valid = 1'b0;
    for (int n = 0; n < 2; n++) begin
      sample_point();
      checks++;
      if (rs2_busy !== 1'b1) $display("FAIL same_busy%0d: got %b want 1", n, rs2_busy);
      else passed++;
      drive_point();
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_x0();
    set_req(WB_CSR, 5'd0, 32'hFFFF_FFFF);
    sample_point();
    checks++;
    if (req_ready !== 3'b100) $display("FAIL x0_ready: got %b want 100", req_ready);
    else passed++;
    exp_q.push_back({1'b0, 5'd0, 32'hFFFF_FFFF});
    drive_point();
    clear_reqs();
    want = exp_q.pop_front();
    got  = {wen, waddr, wdata};
    checks++;
    if (got !== want)
      $display("FAIL x0_write: got wen=%b waddr=%0d wdata=%h want wen=%b waddr=%0d wdata=%h",
               got.wen, got.addr, got.data, want.wen, want.addr, want.data);
    else passed++;
    iss_valid = 1'b1; iss_rd = 5'd0; rs1 = 5'd0;
    for (int n = 0; n < 4; n++) begin
      sample_point();
      checks++;
      if ({iss_ready, rs1_busy} !== 2'b10)
        $display("FAIL x0_issue%0d: got iss_ready=%b rs1_busy=%b want 1/0", n, iss_ready, rs1_busy);
      else passed++;
      drive_point();
    end
    iss_valid = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_flush();
    rs1 = 5'd3; rs2 = 5'd4;
    iss_valid = 1'b1; iss_rd = 5'd3;
    drive_point();
    iss_rd = 5'd4;
    drive_point();
    iss_valid = 1'b0;
    set_req(WB_LSU, 5'd4, 32'h0000_0044);
    sample_point();
    checks++;
    if ({rs1_busy, rs2_busy, req_ready} !== {1'b1, 1'b1, 3'b010})
      $display("FAIL flush_pre: got rs1_busy=%b rs2_busy=%b req_ready=%b want 1/1/010",
               rs1_busy, rs2_busy, req_ready);
    else passed++;
    exp_q.push_back({1'b1, 5'd4, 32'h0000_0044});
    drive_point();
    want = exp_q.pop_front();
    got  = {wen, waddr, wdata};
    checks++;
    if (got !== want)
      $display("FAIL flush_prewrite: got wen=%b waddr=%0d wdata=%h want wen=%b waddr=%0d wdata=%h",
               got.wen, got.addr, got.data, want.wen, want.addr, want.data);
    else passed++;
    flush = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(20 + i), DW'(32'hF0 + i));
    sample_point();
    checks++;
    if (req_ready !== 3'b000) $display("FAIL flush_ready: got %b want 000", req_ready);
    else passed++;
    drive_point();
    flush = 1'b0;
    checks++;
    if (wen !== 1'b0) $display("FAIL flush_wen: got %b want 0", wen);
    else passed++;
    sample_point();
    checks++;
    if ({rs1_busy, rs2_busy} !== 2'b00)
      $display("FAIL flush_busy: got rs1_busy=%b rs2_busy=%b want 0/0", rs1_busy, rs2_busy);
    else passed++;
    // last was LSU before the flush and must survive it: CSR is next
    checks++;
    if (req_ready !== 3'b100) $display("FAIL flush_last_kept: got %b want 100", req_ready);
    else passed++;
    exp_q.push_back({1'b1, 5'd22, 32'h0000_00F2});
    drive_point();
    clear_reqs();
    want = exp_q.pop_front();
    got  = {wen, waddr, wdata};
    checks++;
    if (got !== want)
      $display("FAIL flush_postwrite: got wen=%b waddr=%0d wdata=%h want wen=%b waddr=%0d wdata=%h",
               got.wen, got.addr, got.data, want.wen, want.addr, want.data);
    else passed++;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_async_reset();
    set_req(WB_EXU, 5'd12, 32'h0000_C0DE);
    sample_point();
    checks++;
    if (req_ready !== 3'b001) $display("FAIL arst_grant: got %b want 001", req_ready);
    else passed++;
    drive_point();
    clear_reqs();
    checks++;
    if ({wen, waddr} !== {1'b1, 5'd12}) $display("FAIL arst_inflight: got wen=%b waddr=%0d want 1/12", wen, waddr);
    else passed++;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({wen, waddr, wdata} !== {1'b0, 5'd0, 32'd0})
      $display("FAIL arst_drop: got wen=%b waddr=%0d wdata=%h want 0/0/0", wen, waddr, wdata);
    else passed++;
    drive_point();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(24 + i), DW'(i));
    sample_point();
    checks++;
    if (req_ready !== 3'b001) $display("FAIL arst_last: got %b want 001", req_ready);
    else passed++;
    drive_point();
    clear_reqs();
  endtask

  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_saturate();
    test_same_edge();
    test_x0();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
